// File: rtl/canonical_huffman_decoder_pkg.sv
// canonical_huffman_decoder_pkg: shared sizes, FSM encoding and table-entry type for the canonical Huffman path
package canonical_huffman_decoder_pkg;
  localparam int NUM_SYML = 20;
  localparam int MAX_LEN = 9;
  localparam int SYML_W = 8;
  localparam int LEN_W = 4;
  localparam int IDX_W = $clog2(NUM_SYML + 1);
  localparam int CODE_W = MAX_LEN + 1;
  typedef enum logic [1:0] {LOAD, BUILD, DECODE, ERR} state_t;
  typedef struct packed {
    logic [SYML_W-1:0] syml;
    logic [LEN_W-1:0] len;
  } tbl_entry_t;
endpackage

// File: rtl/huffman_canon_table.sv
// huffman_canon_table: length counts, canonical first-code/first-index build and codeword lookup
module huffman_canon_table
  import canonical_huffman_decoder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_wr,
  input  tbl_entry_t         i_entry,
  input  logic               i_build,
  input  logic [MAX_LEN-1:0] i_acc,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_full,
  output logic               o_step_err,
  output logic               o_last,
  output logic               o_match,
  output logic               o_dead,
  output logic [SYML_W-1:0]  o_syml
);
  logic [IDX_W-1:0] r_count [MAX_LEN+1];
  logic [CODE_W-1:0] r_first_code [MAX_LEN+1];
  logic [IDX_W-1:0] r_first_idx [MAX_LEN+1];
  logic [SYML_W-1:0] r_sym_mem [NUM_SYML];
  logic [IDX_W-1:0] r_index, r_idx;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W:0] r_end;
  logic [LEN_W-1:0] r_step;
  logic [CODE_W:0] w_sum, w_limit, w_prefix;
  logic [CODE_W-1:0] w_acc, w_diff;
  logic [IDX_W-1:0] w_addr;
  assign w_sum = {1'b0, r_code} + (CODE_W+1)'(r_count[r_step]);
  assign w_limit = (CODE_W+1)'(1) << r_step;
  assign o_full = r_index == IDX_W'(NUM_SYML);
  assign o_last = r_step == LEN_W'(MAX_LEN);
  assign o_step_err = i_build && (w_sum > w_limit || r_index == '0);
  assign w_acc = {1'b0, i_acc};
  assign w_diff = w_acc - r_first_code[i_len];
  assign o_match = w_acc >= r_first_code[i_len] && w_diff < CODE_W'(r_count[i_len]);
  assign w_addr = r_first_idx[i_len] + w_diff[IDX_W-1:0];
  assign o_syml = r_sym_mem[w_addr];
  // an unmatched prefix is dead once it lies beyond the last code of the longest length
  assign w_prefix = (CODE_W+1)'(i_acc) << (LEN_W'(MAX_LEN) - i_len);
  assign o_dead = !o_match && (i_len == LEN_W'(MAX_LEN) || w_prefix >= r_end);
  // length histogram during load, then one canonical length per cycle during build
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k <= MAX_LEN; k++) begin
        r_count[k] <= '0;
        r_first_code[k] <= '0;
        r_first_idx[k] <= '0;
      end
      r_index <= '0;
      r_idx <= '0;
      r_code <= '0;
      r_end <= '0;
      r_step <= LEN_W'(1);
    end else begin
      if (i_wr) begin
        r_count[i_entry.len] <= r_count[i_entry.len] + 1'b1;
        r_index <= r_index + 1'b1;
      end
      if (i_build) begin
        r_first_code[r_step] <= r_code;
        r_first_idx[r_step] <= r_idx;
        r_code <= CODE_W'(w_sum << 1);
        r_idx <= r_idx + r_count[r_step];
        r_step <= r_step + 1'b1;
        if (o_last) r_end <= w_sum;
      end
    end
  end
  // symbol store in canonical order
  always_ff @(posedge clk) begin
    if (i_wr) r_sym_mem[r_index] <= i_entry.syml;
  end
endmodule

// File: rtl/canonical_huffman_decoder.sv
// canonical_huffman_decoder: table load, canonical build and bit-serial decode to 8-bit symbols
module canonical_huffman_decoder
  import canonical_huffman_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tbl_enb,
  input  logic [SYML_W-1:0] tbl_syml,
  input  logic [LEN_W-1:0]  tbl_len,
  input  logic              tbl_done,
  input  logic              bit_enb,
  input  logic              bit_in,
  output logic              bit_ready,
  output logic [SYML_W-1:0] Syml_out,
  output logic              Syml_pulse,
  output logic              tbl_err,
  output logic              dec_err
);
  state_t r_state;
  logic [MAX_LEN-2:0] r_acc;
  logic [LEN_W-1:0] r_len;
  logic w_full, w_step_err, w_last, w_match, w_dead, w_bad, w_wr;
  logic [SYML_W-1:0] w_syml;
  logic [MAX_LEN-1:0] w_acc_n;
  logic [LEN_W-1:0] w_len_n;
  assign w_bad = r_state == LOAD && tbl_enb && tbl_len != '0 && (tbl_len > LEN_W'(MAX_LEN) || w_full);
  assign w_wr = r_state == LOAD && tbl_enb && tbl_len != '0 && !w_bad;
  assign w_acc_n = {r_acc, bit_in};
  assign w_len_n = r_len + 1'b1;
  huffman_canon_table u_table (
    .clk(clk),
    .reset(reset),
    .i_wr(w_wr),
    .i_entry({tbl_syml, tbl_len}),
    .i_build(r_state == BUILD),
    .i_acc(w_acc_n),
    .i_len(w_len_n),
    .o_full(w_full),
    .o_step_err(w_step_err),
    .o_last(w_last),
    .o_match(w_match),
    .o_dead(w_dead),
    .o_syml(w_syml)
  );
  // phase FSM, bit accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= LOAD;
      r_acc <= '0;
      r_len <= '0;
      bit_ready <= 1'b0;
      Syml_out <= '0;
      Syml_pulse <= 1'b0;
      tbl_err <= 1'b0;
      dec_err <= 1'b0;
    end else begin
      Syml_pulse <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_bad) begin
            tbl_err <= 1'b1;
            r_state <= ERR;
          end else if (tbl_done) r_state <= BUILD;
        end
        BUILD: begin
          if (w_step_err) begin
            tbl_err <= 1'b1;
            r_state <= ERR;
          end else if (w_last) begin
            bit_ready <= 1'b1;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          if (bit_enb) begin
            if (w_match) begin
              Syml_pulse <= 1'b1;
              Syml_out <= w_syml;
              r_acc <= '0;
              r_len <= '0;
            end else if (w_dead) begin
              dec_err <= 1'b1;
              bit_ready <= 1'b0;
              r_state <= ERR;
            end else begin
              r_acc <= w_acc_n[MAX_LEN-2:0];
              r_len <= w_len_n;
            end
          end
        end
        default: bit_ready <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_canonical_huffman_decoder.sv
// tb_canonical_huffman_decoder: directed table-driven checks of load, build, decode and error paths
module tb_canonical_huffman_decoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tbl_enb = 1'b0, tbl_done = 1'b0, bit_enb = 1'b0, bit_in = 1'b0;
  logic [7:0] tbl_syml = '0;
  logic [3:0] tbl_len = '0;
  logic bit_ready, Syml_pulse, tbl_err, dec_err;
  logic [7:0] Syml_out;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic b;
    logic en;
    logic exp_pulse;
    logic [7:0] exp_sym;
  } vec_t;
  vec_t tv [10];

  canonical_huffman_decoder dut (
    .clk(clk), .reset(reset), .tbl_enb(tbl_enb), .tbl_syml(tbl_syml), .tbl_len(tbl_len),
    .tbl_done(tbl_done), .bit_enb(bit_enb), .bit_in(bit_in), .bit_ready(bit_ready),
    .Syml_out(Syml_out), .Syml_pulse(Syml_pulse), .tbl_err(tbl_err), .dec_err(dec_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic put_entry(input logic [7:0] s, input logic [3:0] l, input logic d);
    tbl_enb = 1'b1;
    tbl_syml = s;
    tbl_len = l;
    tbl_done = d;
    @(negedge clk);
    tbl_enb = 1'b0;
    tbl_done = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic en);
    bit_enb = en;
    bit_in = b;
    @(negedge clk);
    bit_enb = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    for (int k = 0; k < 20 && !bit_ready; k++) @(negedge clk);
    check(name, bit_ready, 1);
  endtask

  task automatic load_abcd();
    put_entry(8'h41, 4'd1, 1'b0);
    put_entry(8'h42, 4'd2, 1'b0);
    put_entry(8'h43, 4'd3, 1'b0);
    put_entry(8'h44, 4'd3, 1'b1);
  endtask

  initial begin
    logic seen;
    int s, len;
    logic [4:0] code;
    tv[0] = '{1'b0, 1'b1, 1'b1, 8'h41};
    tv[1] = '{1'b1, 1'b1, 1'b0, 8'h00};
    tv[2] = '{1'b0, 1'b0, 1'b0, 8'h00};
    tv[3] = '{1'b0, 1'b1, 1'b1, 8'h42};
    tv[4] = '{1'b1, 1'b1, 1'b0, 8'h00};
    tv[5] = '{1'b1, 1'b1, 1'b0, 8'h00};
    tv[6] = '{1'b0, 1'b1, 1'b1, 8'h43};
    tv[7] = '{1'b1, 1'b1, 1'b0, 8'h00};
    tv[8] = '{1'b1, 1'b1, 1'b0, 8'h00};
    tv[9] = '{1'b1, 1'b1, 1'b1, 8'h44};
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst_outputs", {bit_ready, Syml_pulse, tbl_err, dec_err, Syml_out}, 0);

    // four-symbol table, last entry together with tbl_done
    load_abcd();
    check("load_not_ready", bit_ready, 0);
    wait_ready("abcd_ready");
    for (int i = 0; i < 10; i++) begin
      send_bit(tv[i].b, tv[i].en);
      check($sformatf("abcd_pulse%0d", i), Syml_pulse, tv[i].exp_pulse);
      if (tv[i].exp_pulse) check($sformatf("abcd_sym%0d", i), Syml_out, tv[i].exp_sym);
    end
    check("abcd_no_err", {tbl_err, dec_err}, 0);

    // single-symbol alphabet, then an invalid bit
    do_reset();
    put_entry(8'h7F, 4'd1, 1'b1);
    wait_ready("one_ready");
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0, 1'b1);
      check("one_pulse", Syml_pulse, 1);
      check("one_sym", Syml_out, 8'h7F);
    end
    send_bit(1'b1, 1'b1);
    check("one_dec_err", dec_err, 1);
    check("one_not_ready", bit_ready, 0);
    check("one_no_pulse", Syml_pulse, 0);
    send_bit(1'b0, 1'b1);
    check("err_no_pulse", Syml_pulse, 0);

    // oversubscribed lengths {1,1,2}
    do_reset();
    put_entry(8'h10, 4'd1, 1'b0);
    put_entry(8'h11, 4'd1, 1'b0);
    put_entry(8'h12, 4'd2, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      seen |= bit_ready;
      @(negedge clk);
    end
    check("kraft_never_ready", seen, 0);
    check("kraft_tbl_err", tbl_err, 1);

    // all-zero table
    do_reset();
    put_entry(8'h20, 4'd0, 1'b1);
    for (int k = 0; k < 12; k++) @(negedge clk);
    check("empty_tbl_err", {tbl_err, bit_ready}, 2'b10);

    // length above MAX_LEN
    do_reset();
    put_entry(8'h30, 4'd9, 1'b0);
    check("len9_ok", tbl_err, 0);
    put_entry(8'h31, 4'd10, 1'b0);
    check("len10_err", tbl_err, 1);

    // table overflow at the 21st non-zero entry
    do_reset();
    for (int i = 0; i < 20; i++) put_entry(8'(i), 4'd5, 1'b0);
    check("full20_ok", tbl_err, 0);
    put_entry(8'h50, 4'd0, 1'b0);
    check("full_zero_len_ignored", tbl_err, 0);
    put_entry(8'h51, 4'd5, 1'b0);
    check("overflow_err", tbl_err, 1);

    // 20-symbol Kraft-complete table: 0x00..0x0B at L4, 0x0C..0x13 at L5
    do_reset();
    for (int i = 0; i < 20; i++) put_entry(8'(i), i < 12 ? 4'd4 : 4'd5, i == 19);
    wait_ready("big_ready");
    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(0, 19);
      len = s < 12 ? 4 : 5;
      code = s < 12 ? 5'(s) : 5'(s + 12);
      for (int j = len - 1; j >= 0; j--) begin
        if ($urandom_range(0, 3) == 0) begin
          send_bit(1'($urandom_range(0, 1)), 1'b0);
          check("big_gap_no_pulse", Syml_pulse, 0);
        end
        send_bit(code[j], 1'b1);
        check($sformatf("big_pulse_s%0d_b%0d", s, j), Syml_pulse, j == 0);
        if (j == 0) check($sformatf("big_sym%0d", i), Syml_out, s);
      end
    end
    check("big_no_err", {tbl_err, dec_err, bit_ready}, 3'b001);

    // reset after 2 of 3 bits, reload, decode without stale accumulator
    do_reset();
    load_abcd();
    wait_ready("mid_ready");
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    check("mid_pre_sym", Syml_out, 8'h42);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    check("mid_pending", Syml_pulse, 0);
    do_reset();
    check("mid_rst_outputs", {bit_ready, Syml_pulse, tbl_err, dec_err, Syml_out}, 0);
    load_abcd();
    wait_ready("reload_ready");
    send_bit(1'b0, 1'b1);
    check("reload_pulse_a", Syml_pulse, 1);
    check("reload_sym_a", Syml_out, 8'h41);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    check("reload_sym_c", {Syml_pulse, Syml_out}, 9'h143);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
